// File: rtl/uart_tx_stream_if.sv
// Word stream into the UART transmitter: 32-bit data with a stb/ack handshake.
// A word moves on a rising clk edge where in_stb and in_ack are both high.
interface uart_tx_stream_if;
  logic [31:0] in_data;
  logic        in_stb;
  logic        in_ack;

  modport master (output in_data, output in_stb, input  in_ack);
  modport slave  (input  in_data, input  in_stb, output in_ack);
endinterface

// File: rtl/uart_tx_stream.sv
// Buffers stream words in a small FIFO and sends bits [7:0] of each word as
// 8N1 UART frames, LSB first, with one idle cycle between back-to-back frames.
module uart_tx_stream #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_stream_if.slave   s_in,
  output logic              o_tx,
  output logic              o_busy
);

  localparam int DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int BAUD_W  = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ack;

  state_t            r_state;
  logic [7:0]        r_shift;
  logic [2:0]        r_bit_idx;
  logic [BAUD_W-1:0] r_baud;
  logic              r_tx;
  logic              r_busy;

  logic              w_push;
  logic              w_pop;
  logic              w_baud_end;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_unused_upper;

  // The upper 24 bits of each word are accepted but never transmitted.
  assign w_unused_upper = ^s_in.in_data[31:8];

  assign w_push     = s_in.in_stb & r_ack;
  assign w_pop      = (r_state == ST_IDLE) && (r_count != '0);
  assign w_baud_end = (r_baud == BAUD_W'(DIVISOR - 1));

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  assign s_in.in_ack = r_ack;
  assign o_tx        = r_tx;
  assign o_busy      = r_busy;

  // Storage carries no reset; emptiness is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_in.in_data[7:0];
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ack    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_next;
      r_ack   <= (w_count_next < CNT_W'(FIFO_DEPTH));
    end
  end

  // tx and busy are assigned with the value belonging to the state being
  // entered, so both are registered yet line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_baud    <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_baud  <= '0;
            r_state <= ST_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_busy <= (w_count_next != '0);
          end
        end
        ST_START: begin
          r_busy <= 1'b1;
          if (w_baud_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
            r_tx      <= r_shift[0];
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          r_busy <= 1'b1;
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_baud_end) begin
            r_baud  <= '0;
            r_state <= ST_IDLE;
            r_busy  <= (w_count_next != '0);
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
            r_busy <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboard bench: accepted bytes are queued by a handshake monitor and
// compared against frames decoded cycle by cycle from the serial line.
module tb_uart_tx_stream;

  localparam int DIV = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  logic busy;

  uart_tx_stream_if s_if ();

  uart_tx_stream #(
    .CLOCK_FREQUENCY(16),
    .BAUD_RATE      (1),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_in  (s_if),
    .o_tx  (tx),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0] exp_q[$];
  int         cyc = 0;
  logic       dec_active = 1'b0;
  int         dec_cnt = 0;
  logic       dec_bad = 1'b0;
  logic [7:0] dec_byte = 8'h00;
  logic [7:0] dec_exp = 8'h00;
  logic [7:0] last_byte = 8'h00;
  int         frames_started = 0;
  int         frames_done = 0;
  int         last_start = -1;
  logic       gap_chk = 1'b0;
  int         bi;
  logic       eb;

  // Handshake monitor: the scoreboard entry is the low byte of each accepted word.
  always @(posedge clk) begin
    if (rst_n && s_if.in_stb && s_if.in_ack) begin
      exp_q.push_back(s_if.in_data[7:0]);
    end
  end

  // Line decoder: checks every cycle of every frame against the expected byte.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      dec_active = 1'b0;
    end else if (!dec_active && tx == 1'b0) begin
      dec_active = 1'b1;
      dec_cnt    = 0;
      dec_bad    = 1'b0;
      dec_byte   = 8'h00;
      frames_started++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_frame", 32'(exp_q.size()), 32'd1);
        dec_exp = 8'h00;
      end else begin
        dec_exp = exp_q[0];
      end
      if (gap_chk && last_start >= 0) begin
        check_eq("frame_period", 32'(cyc - last_start), 32'd161);
      end
      last_start = cyc;
    end
    if (dec_active) begin
      if (dec_cnt < DIV) begin
        eb = 1'b0;
      end else if (dec_cnt < 9 * DIV) begin
        bi = (dec_cnt - DIV) / DIV;
        eb = dec_exp[bi];
        if ((dec_cnt % DIV) == DIV / 2) begin
          dec_byte[bi] = tx;
        end
      end else begin
        eb = 1'b1;
      end
      if (tx !== eb) begin
        dec_bad = 1'b1;
      end
      if (dec_cnt == 10 * DIV - 1) begin
        check_eq("frame_byte", 32'(dec_byte), 32'(dec_exp));
        check_eq("frame_shape", 32'(dec_bad), 32'd0);
        check_eq("busy_in_stop", 32'(busy), 32'd1);
        if (exp_q.size() > 0) begin
          void'(exp_q.pop_front());
        end
        last_byte  = dec_byte;
        frames_done++;
        dec_active = 1'b0;
      end else begin
        dec_cnt++;
      end
    end
  end

  task automatic push_word(input logic [31:0] d);
    int t;
    t = 0;
    @(negedge clk);
    s_if.in_data = d;
    s_if.in_stb  = 1'b1;
    while (!s_if.in_ack && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_eq("push_ack_wait", 32'(s_if.in_ack), 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_if.in_stb = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    while (t < limit && (busy || exp_q.size() != 0 || dec_active)) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_busy", 32'(busy), 32'd0);
    check_eq("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d;
    int accepted;
    int started_before;
    int done_before;
    logic seen_low;
    logic prev_ack;
    logic prev_tx;

    s_if.in_data = 32'h0;
    s_if.in_stb  = 1'b0;

    // Reset held with random stimulus on the input side.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_if.in_data = $urandom;
      s_if.in_stb  = 1'($urandom_range(0, 1));
      #1;
      check_eq("rst_tx", 32'(tx), 32'd1);
      check_eq("rst_ack", 32'(s_if.in_ack), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
    end
    @(negedge clk);
    s_if.in_stb = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ack_after_release", 32'(s_if.in_ack), 32'd1);

    // Single frame with exact latency and busy timing.
    @(negedge clk);
    s_if.in_data = 32'h0000_0055;
    s_if.in_stb  = 1'b1;
    check_eq("ack_idle", 32'(s_if.in_ack), 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_if.in_stb = 1'b0;
    check_eq("tx_before_start", 32'(tx), 32'd1);
    @(negedge clk);
    check_eq("tx_start_latency", 32'(tx), 32'd0);
    repeat (159) @(negedge clk);
    check_eq("busy_before_end", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("busy_fall", 32'(busy), 32'd0);
    check_eq("byte_55", 32'(last_byte), 32'h55);

    // Upper bits never reach the line.
    push_word(32'hFFFF_FF41);
    wait_idle(1000);
    check_eq("upper_ignored", 32'(last_byte), 32'h41);
    push_word(32'h0000_0041);
    wait_idle(1000);
    check_eq("upper_clear", 32'(last_byte), 32'h41);

    // Back-pressure with a continuously offered stream.
    done_before = frames_done;
    accepted    = 0;
    seen_low    = 1'b0;
    gap_chk     = 1'b1;
    last_start  = -1;
    d           = 1;
    @(negedge clk);
    s_if.in_data = 32'(d);
    s_if.in_stb  = 1'b1;
    prev_ack = s_if.in_ack;
    prev_tx  = tx;
    for (int t = 0; t < 4000 && d <= 12; t++) begin
      if (s_if.in_ack && !prev_ack) begin
        check_eq("ack_rise_at_pop", {30'd0, prev_tx, tx}, 32'd2);
      end
      prev_ack = s_if.in_ack;
      prev_tx  = tx;
      if (s_if.in_ack) begin
        @(posedge clk);
        accepted++;
        @(negedge clk);
        d++;
        s_if.in_data = 32'(d);
      end else begin
        if (!seen_low) begin
          check_eq("accepted_before_full", 32'(accepted), 32'd5);
          seen_low = 1'b1;
        end
        @(negedge clk);
      end
    end
    s_if.in_stb = 1'b0;
    check_eq("ack_fell", 32'(seen_low), 32'd1);
    check_eq("accepted_total", 32'(accepted), 32'd12);
    wait_idle(4000);
    gap_chk = 1'b0;
    check_eq("bp_frames", 32'(frames_done - done_before), 32'd12);

    // Reset in the middle of a data bit.
    push_word(32'h0000_0000);
    push_word(32'h0000_0022);
    push_word(32'h0000_0033);
    repeat (60) @(negedge clk);
    check_eq("tx_low_before_reset", 32'(tx), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_tx", 32'(tx), 32'd1);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_ack", 32'(s_if.in_ack), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    started_before = frames_started;
    repeat (200) @(negedge clk);
    check_eq("no_frame_after_reset", 32'(frames_started), 32'(started_before));
    check_eq("idle_after_reset", 32'(tx), 32'd1);
    push_word(32'h0000_00A5);
    wait_idle(1000);
    check_eq("byte_a5", 32'(last_byte), 32'hA5);

    // Pointer wrap with random producer gaps.
    done_before = frames_done;
    for (int i = 0; i < 20; i++) begin
      push_word(32'(i));
      repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    wait_idle(8000);
    check_eq("wrap_frames", 32'(frames_done - done_before), 32'd20);
    check_eq("wrap_last", 32'(last_byte), 32'h13);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
